qpsk_symbol_scheduler: RTL

QPSK_SYMBOL_SCHEDULER -- requirements
Module: qpsk_symbol_scheduler

---
 rtl/qpsk_pkg.sv | 24 ++
 rtl/qpsk_sym_reg.sv | 33 +++
 rtl/qpsk_symbol_scheduler.sv | 128 ++++++++++++
 3 files changed

// File: rtl/qpsk_pkg.sv
// Shared definitions for the QPSK symbol scheduler: FSM encoding, counter
// widths and the fixed preamble constellation points.
package qpsk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_COLLECT_I,
        ST_COLLECT_Q,
        ST_DONE
    } state_t;

    localparam int K_W    = 8;
    localparam int PCNT_W = 16;

    // Preamble symbols packed as {I, Q}; the pattern alternates starting at (1,1).
    localparam logic [1:0] PRE_SYM_EVEN = 2'b11;
    localparam logic [1:0] PRE_SYM_ODD  = 2'b00;

    function automatic logic [1:0] preamble_sym(input logic [K_W-1:0] k);
        return k[0] ? PRE_SYM_ODD : PRE_SYM_EVEN;
    endfunction

endpackage

// File: rtl/qpsk_sym_reg.sv
// Single-entry output holding slot: loads a new {I,Q} symbol when free,
// holds it while the consumer stalls, and drops valid on an accept with no reload.
module qpsk_sym_reg (
    input  logic clk1,
    input  logic rst,
    input  logic load,
    input  logic load_i,
    input  logic load_q,
    input  logic sym_ready,
    output logic sym_i,
    output logic sym_q,
    output logic sym_valid,
    output logic slot_free
);

    assign slot_free = !sym_valid || sym_ready;

    // load is only raised by the scheduler while slot_free is true
    always_ff @(posedge clk1) begin
        if (rst) begin
            sym_i     <= 1'b0;
            sym_q     <= 1'b0;
            sym_valid <= 1'b0;
        end else if (load) begin
            sym_i     <= load_i;
            sym_q     <= load_q;
            sym_valid <= 1'b1;
        end else if (sym_ready) begin
            sym_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/qpsk_symbol_scheduler.sv
// Frame scheduler: emits an alternating preamble, then pairs serial payload
// bits into QPSK symbols (first bit -> I, second -> Q) through a holding slot.
module qpsk_symbol_scheduler
    import qpsk_pkg::*;
#(
    parameter int PREAMBLE_LEN = 8,
    parameter int PAYLOAD_SYMS = 64
) (
    input  logic       clk1,
    input  logic       rst,
    input  logic       start,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic       bit_ready,
    output logic [1:0] Ichannel,
    output logic [1:0] Qchannel,
    output logic       sym_valid,
    input  logic       sym_ready,
    output logic       frame_busy,
    output logic       frame_done
);

    localparam logic [K_W-1:0]    K_LAST    = K_W'(PREAMBLE_LEN - 1);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PAYLOAD_SYMS - 1);

    state_t              state;
    state_t              state_nxt;
    logic [K_W-1:0]      k;
    logic [PCNT_W-1:0]   pcnt;
    logic                pend_i;
    logic                slot_free;
    logic                load;
    logic                load_i;
    logic                load_q;
    logic                sym_i;
    logic                sym_q;
    logic [1:0]          pre_sym;

    always_ff @(posedge clk1) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:      if (start) state_nxt = ST_PREAMBLE;
            ST_PREAMBLE:  if (slot_free && k == K_LAST) state_nxt = ST_COLLECT_I;
            ST_COLLECT_I: if (bit_valid) state_nxt = ST_COLLECT_Q;
            ST_COLLECT_Q: begin
                if (bit_valid && slot_free)
                    state_nxt = (pcnt == PCNT_LAST) ? ST_DONE : ST_COLLECT_I;
            end
            ST_DONE:      if (slot_free) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        load       = 1'b0;
        load_i     = 1'b0;
        load_q     = 1'b0;
        bit_ready  = 1'b0;
        frame_done = 1'b0;
        pre_sym    = preamble_sym(k);
        unique case (state)
            ST_PREAMBLE: begin
                if (slot_free) begin
                    load   = 1'b1;
                    load_i = pre_sym[1];
                    load_q = pre_sym[0];
                end
            end
            ST_COLLECT_I: bit_ready = 1'b1;
            ST_COLLECT_Q: begin
                // the Q bit is only taken when its symbol can enter the slot
                bit_ready = slot_free;
                if (bit_valid && slot_free) begin
                    load   = 1'b1;
                    load_i = pend_i;
                    load_q = bit_in;
                end
            end
            ST_DONE:  frame_done = slot_free;
            default: ;
        endcase
    end

    assign frame_busy = (state != ST_IDLE);

    always_ff @(posedge clk1) begin
        if (rst) begin
            k      <= '0;
            pcnt   <= '0;
            pend_i <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        k    <= '0;
                        pcnt <= '0;
                    end
                end
                ST_PREAMBLE:  if (slot_free) k <= k + K_W'(1);
                ST_COLLECT_I: if (bit_valid) pend_i <= bit_in;
                ST_COLLECT_Q: if (bit_valid && slot_free) pcnt <= pcnt + PCNT_W'(1);
                default: ;
            endcase
        end
    end

    qpsk_sym_reg u_sym_reg (
        .clk1      (clk1),
        .rst       (rst),
        .load      (load),
        .load_i    (load_i),
        .load_q    (load_q),
        .sym_ready (sym_ready),
        .sym_i     (sym_i),
        .sym_q     (sym_q),
        .sym_valid (sym_valid),
        .slot_free (slot_free)
    );

    assign Ichannel = {1'b0, sym_i};
    assign Qchannel = {1'b0, sym_q};

endmodule
